// File: rtl/multiport_register_file_pkg.sv
// Shared definitions for the multiport register file.
//   rf_state_e     : clear-sequencer state encoding (CLEAR=0, READY=1)
//   DEFAULT_XLEN   : default data width
//   DEFAULT_NREGS  : default number of architectural registers
//   rf_aw()        : address width for a given register count
package multiport_register_file_pkg;

  typedef enum logic {
    RF_ST_CLEAR = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

  localparam int DEFAULT_XLEN  = 64;
  localparam int DEFAULT_NREGS = 32;

  // Address width derived from the register count; never narrower than 1 bit.
  function automatic int rf_aw(input int nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Bus interface of the multiport register file.
//   clear_req  : pulse, start a clear sequence (honoured only while ready=1)
//   wr_en/wr_addr/wr_data : single write port
//   rd_addr    : NRD packed read indices, port i = rd_addr[i*AW +: AW]
//   rd_data    : NRD packed read results, port i = rd_data[i*XLEN +: XLEN]
//   ready      : file usable (0 while clearing)
//   wr_dropped : one-cycle pulse, previous cycle's write was discarded
// Modports: master = decode/writeback side, slave = register file.
interface multiport_register_file_if
  import multiport_register_file_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int NREGS = DEFAULT_NREGS,
  parameter int NRD   = 2
);
  localparam int AW = rf_aw(NREGS);

  logic                clear_req;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                ready;
  logic                wr_dropped;

  modport master (
    output clear_req, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, ready, wr_dropped
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, ready, wr_dropped
  );

endinterface

// File: rtl/multiport_register_file_clear_fsm.sv
// Clear sequencer for the register file.
//   clk, reset : clock and synchronous active-high reset
//   clear_req  : request a new clear (ignored unless in READY)
//   state      : current sequencer state
//   ready      : registered, high once every entry has been zeroed
//   clr_we     : storage write-enable for the clear path
//   clr_idx    : storage index being zeroed this cycle
// After reset (or an accepted clear_req) one entry is zeroed per edge,
// index 0 up to NREGS-1; the edge writing the last entry enters READY.
module multiport_register_file_clear_fsm
  import multiport_register_file_pkg::*;
#(
  parameter int NREGS = DEFAULT_NREGS,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  output rf_state_e     state,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    clr_we    = 1'b0;
    case (state_q)
      RF_ST_CLEAR: begin
        // clear_req is deliberately not looked at here: the running
        // sequence never restarts on a request.
        clr_we = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = RF_ST_READY;
          ready_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      RF_ST_READY: begin
        if (clear_req) begin
          state_d   = RF_ST_CLEAR;
          clr_idx_d = '0;
          ready_d   = 1'b0;
        end
      end
      default: begin
        state_d   = RF_ST_CLEAR;
        clr_idx_d = '0;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RF_ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  assign state   = state_q;
  assign ready   = ready_q;
  assign clr_idx = clr_idx_q;

endmodule

// File: rtl/multiport_register_file.sv
// Integer register file: NRD combinational read ports, one synchronous
// write port, optional hardwired x0, optional write-to-read bypass and a
// hardware clear sequencer that zeroes storage one entry per cycle.
//   clk   : clock
//   reset : synchronous active-high reset (FSM and flags only, not storage)
//   rf    : slave side of multiport_register_file_if (write port, read
//           ports, clear_req, ready, wr_dropped)
// The interface instance must be built with the same XLEN/NREGS/NRD.
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NREGS    = DEFAULT_NREGS,
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multiport_register_file_if.slave rf
);
  // Derived from NREGS; intentionally not a parameter.
  localparam int AW = rf_aw(NREGS);

  rf_state_e       state;
  logic            ready;
  logic            clr_we;
  logic [AW-1:0]   clr_idx;

  logic [XLEN-1:0] mem [NREGS];

  logic            wr_in_range;
  logic            port_we;
  logic            wr_dropped_q, wr_dropped_d;

  multiport_register_file_clear_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (rf.clear_req),
    .state     (state),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  // Widen by one bit so the compare is meaningful when NREGS == 2**AW.
  assign wr_in_range = ({1'b0, rf.wr_addr} < (AW+1)'(NREGS));

  // x0 writes under ZERO_REG are silently ignored rather than dropped.
  always_comb begin
    port_we = (state == RF_ST_READY) && rf.wr_en && !rf.clear_req && wr_in_range;
    if (ZERO_REG && (rf.wr_addr == '0)) begin
      port_we = 1'b0;
    end
  end

  assign wr_dropped_d = rf.wr_en &&
                        ((state == RF_ST_CLEAR) || rf.clear_req || !wr_in_range);

  // Storage is left alone while reset is asserted; the clear sequence
  // that follows reset is what defines its contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) begin
        mem[clr_idx] <= '0;
      end else if (port_we) begin
        mem[rf.wr_addr] <= rf.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_dropped_q <= 1'b0;
    end else begin
      wr_dropped_q <= wr_dropped_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;

      assign ra = rf.rd_addr[gi*AW +: AW];

      always_comb begin
        rd = '0;
        if (!ready) begin
          rd = '0;
        end else if ({1'b0, ra} >= (AW+1)'(NREGS)) begin
          rd = '0;
        end else if (ZERO_REG && (ra == '0)) begin
          rd = '0;
        end else if (BYPASS && rf.wr_en && !rf.clear_req && (ra == rf.wr_addr)) begin
          rd = rf.wr_data;
        end else begin
          rd = mem[ra];
        end
      end

      assign rf.rd_data[gi*XLEN +: XLEN] = rd;
    end
  endgenerate

  assign rf.ready      = ready;
  assign rf.wr_dropped = wr_dropped_q;

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: instance A uses the defaults
// (32 regs, bypass, hardwired x0); instance B uses 24 regs, no bypass,
// ordinary x0. Both share the stimulus signals; sel picks whose outputs
// are compared. Instance B is held in reset while A is exercised.
module tb_multiport_register_file;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [63:0] e0;
    logic [63:0] e1;
    logic        edrop;
  } vec_t;

  logic        clk;
  logic        reset_a, reset_b;
  logic        clear_req, wr_en;
  logic [4:0]  wr_addr, ra0, ra1;
  logic [63:0] wr_data;
  logic        sel;
  logic [63:0] rd0, rd1;
  logic        rdy, drp;

  int errors = 0;
  int checks = 0;

  logic        drop_q [$];
  logic [63:0] rd_q   [$];

  vec_t tab_a [10];
  vec_t tab_b [8];

  multiport_register_file_if #(.XLEN(64), .NREGS(32), .NRD(2)) ifa ();
  multiport_register_file_if #(.XLEN(64), .NREGS(24), .NRD(2)) ifb ();

  multiport_register_file #(
    .XLEN(64), .NREGS(32), .NRD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .rf    (ifa.slave)
  );

  multiport_register_file #(
    .XLEN(64), .NREGS(24), .NRD(2), .BYPASS(1'b0), .ZERO_REG(1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .rf    (ifb.slave)
  );

  assign ifa.clear_req = clear_req;
  assign ifa.wr_en     = wr_en;
  assign ifa.wr_addr   = wr_addr;
  assign ifa.wr_data   = wr_data;
  assign ifa.rd_addr   = {ra1, ra0};
  assign ifb.clear_req = clear_req;
  assign ifb.wr_en     = wr_en;
  assign ifb.wr_addr   = wr_addr;
  assign ifb.wr_data   = wr_data;
  assign ifb.rd_addr   = {ra1, ra0};

  assign rd0 = sel ? ifb.rd_data[63:0]   : ifa.rd_data[63:0];
  assign rd1 = sel ? ifb.rd_data[127:64] : ifa.rd_data[127:64];
  assign rdy = sel ? ifb.ready           : ifa.ready;
  assign drp = sel ? ifb.wr_dropped      : ifa.wr_dropped;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [63:0] e0, input logic [63:0] e1,
                              input logic edrop);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.a0 = a0; v.a1 = a1;
    v.e0 = e0; v.e1 = e1; v.edrop = edrop;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
  endtask

  // Called just after the edge that loaded the clear state. Expects ready
  // to stay low for n-1 edges and rise after the n-th; reads stay 0.
  task automatic count_clear(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      idle_inputs();
      ra0 = 5'(k);
      ra1 = 5'(31 - k);
      #2;
      if (k < n) begin
        check($sformatf("%s_rd0_k%0d", tag, k), rd0, 64'h0);
        check($sformatf("%s_rd1_k%0d", tag, k), rd1, 64'h0);
      end
      @(posedge clk); #1;
      check($sformatf("%s_ready_k%0d", tag, k), 64'(rdy), (k == n) ? 64'd1 : 64'd0);
    end
  endtask

  // One table record: drive, queue expectations, compare reads this cycle
  // and wr_dropped after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    logic [63:0] e;
    logic        ed;
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    clear_req = 1'b0; ra0 = v.a0; ra1 = v.a1;
    rd_q.push_back(v.e0);
    rd_q.push_back(v.e1);
    drop_q.push_back(v.edrop);
    #4;
    e = rd_q.pop_front(); check({tag, "_rd0"}, rd0, e);
    e = rd_q.pop_front(); check({tag, "_rd1"}, rd1, e);
    @(posedge clk); #1;
    ed = drop_q.pop_front();
    check({tag, "_drop"}, 64'(drp), 64'(ed));
  endtask

  initial begin
    tab_a[0] = mk(1'b1, 5'd5,  64'hDEAD_BEEF, 5'd1,  5'd2,  64'h0,         64'h0,         1'b0);
    tab_a[1] = mk(1'b0, 5'd0,  64'h0,         5'd5,  5'd5,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0);
    tab_a[2] = mk(1'b1, 5'd7,  64'h1234,      5'd7,  5'd5,  64'h1234,      64'hDEAD_BEEF, 1'b0);
    tab_a[3] = mk(1'b0, 5'd0,  64'h0,         5'd7,  5'd7,  64'h1234,      64'h1234,      1'b0);
    tab_a[4] = mk(1'b1, 5'd0,  64'hFFFF,      5'd0,  5'd0,  64'h0,         64'h0,         1'b0);
    tab_a[5] = mk(1'b0, 5'd0,  64'h0,         5'd0,  5'd5,  64'h0,         64'hDEAD_BEEF, 1'b0);
    tab_a[6] = mk(1'b1, 5'd5,  64'hAAAA,      5'd5,  5'd6,  64'hAAAA,      64'h0,         1'b0);
    tab_a[7] = mk(1'b1, 5'd31, 64'h55,        5'd31, 5'd30, 64'h55,        64'h0,         1'b0);
    tab_a[8] = mk(1'b0, 5'd0,  64'h0,         5'd31, 5'd5,  64'h55,        64'hAAAA,      1'b0);
    tab_a[9] = mk(1'b1, 5'd3,  64'h33,        5'd3,  5'd3,  64'h33,        64'h33,        1'b0);

    tab_b[0] = mk(1'b1, 5'd7,  64'h1234,      5'd7,  5'd7,  64'h0,         64'h0,         1'b0);
    tab_b[1] = mk(1'b0, 5'd0,  64'h0,         5'd7,  5'd7,  64'h1234,      64'h1234,      1'b0);
    tab_b[2] = mk(1'b1, 5'd0,  64'hFFFF,      5'd0,  5'd7,  64'h0,         64'h1234,      1'b0);
    tab_b[3] = mk(1'b0, 5'd0,  64'h0,         5'd0,  5'd0,  64'hFFFF,      64'hFFFF,      1'b0);
    tab_b[4] = mk(1'b1, 5'd30, 64'hBAD,       5'd30, 5'd23, 64'h0,         64'h0,         1'b1);
    tab_b[5] = mk(1'b0, 5'd0,  64'h0,         5'd30, 5'd24, 64'h0,         64'h0,         1'b0);
    tab_b[6] = mk(1'b1, 5'd23, 64'h77,        5'd23, 5'd22, 64'h0,         64'h0,         1'b0);
    tab_b[7] = mk(1'b0, 5'd0,  64'h0,         5'd23, 5'd0,  64'h77,        64'hFFFF,      1'b0);

    // ---- instance A: reset and initial clear ----
    sel = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;
    idle_inputs(); ra0 = '0; ra1 = '0;
    @(posedge clk); #1;
    reset_a = 1'b0;
    check("a_reset_ready", 64'(rdy), 64'd0);
    check("a_reset_drop",  64'(drp), 64'd0);
    check("a_reset_rd0",   rd0, 64'h0);
    count_clear(32, "a_init");

    // ---- instance A: table ----
    for (int i = 0; i < 10; i++) begin
      run_vec(tab_a[i], $sformatf("a_vec%0d", i));
    end

    // ---- instance A: clear_req overriding a same-cycle write ----
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd9;
    ra0 = 5'd3; ra1 = 5'd3;
    #4;
    check("a_clr_req_rd0_nobypass", rd0, 64'h33);
    @(posedge clk); #1;
    idle_inputs();
    check("a_clr_req_drop",  64'(drp), 64'd1);
    check("a_clr_req_ready", 64'(rdy), 64'd0);
    // A second clear_req plus write mid-sequence: write dropped, no restart.
    for (int k = 1; k <= 32; k++) begin
      idle_inputs();
      if (k == 10) begin
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
      end
      @(posedge clk); #1;
      check($sformatf("a_clr_ready_k%0d", k), 64'(rdy), (k == 32) ? 64'd1 : 64'd0);
      check($sformatf("a_clr_drop_k%0d", k), 64'(drp), (k == 10) ? 64'd1 : 64'd0);
    end
    idle_inputs();
    ra0 = 5'd3; ra1 = 5'd5;
    #3;
    check("a_after_clr_x3", rd0, 64'h0);
    check("a_after_clr_x5", rd1, 64'h0);
    ra0 = 5'd4; ra1 = 5'd31;
    #3;
    check("a_after_clr_x4",  rd0, 64'h0);
    check("a_after_clr_x31", rd1, 64'h0);
    @(posedge clk); #1;

    // ---- instance B: reset in the middle of its clear ----
    sel = 1'b1;
    reset_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("b_partial_ready_k%0d", k), 64'(rdy), 64'd0);
    end
    reset_b = 1'b1;
    @(posedge clk); #1;
    reset_b = 1'b0;
    check("b_rereset_ready", 64'(rdy), 64'd0);
    check("b_rereset_drop",  64'(drp), 64'd0);
    count_clear(24, "b_init");

    // ---- instance B: table ----
    for (int i = 0; i < 8; i++) begin
      run_vec(tab_b[i], $sformatf("b_vec%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
